// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder:
//                state encoding, bus widths, default depth, and the
//                address legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int BE_W               = 4;
    localparam int DMEM_WORDS_DEFAULT = 4096;
    // Wait counter holds LATENCY-1, and LATENCY is at most 15.
    localparam int CNT_W              = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    // An access is illegal when it is not word aligned or when its word
    // index falls beyond the backing array.
    function automatic logic addr_is_bad(input logic [ADDR_W-1:0] addr,
                                         input int unsigned        depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Word-wide storage array, one byte-wide bank per lane.
//                Synchronous write with per-byte enable, combinational read
//                so the responder can register the word on the same edge
//                that commits a store.
//  Ports       : clk     - rising-edge clock
//                wr_en   - write strobe (gated per lane by wr_be)
//                wr_be   - byte-lane enables
//                idx     - word index, shared by read and write
//                wr_data - store data
//                rd_data - word at idx (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_WORDS_DEFAULT,
    parameter int IDX_W       = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    // Each lane owns its own bank, so no two processes ever write the same
    // storage element. Contents are intentionally not reset.
    for (genvar lane = 0; lane < BE_W; lane++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (wr_en && wr_be[lane]) begin
                r_mem[idx] <= wr_data[8*lane +: 8];
            end
        end

        assign rd_data[8*lane +: 8] = r_mem[idx];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-outstanding data-memory responder with a fixed
//                access latency. A request is accepted in IDLE, waits
//                LATENCY edges, then commits (store) or captures (load) and
//                holds the response until the initiator takes it.
//  Ports       : clk, reset_n       - clock, async active-low reset
//                req_valid/ready    - request handshake
//                req_we/addr/wdata/be - request payload
//                resp_valid/ready   - response handshake
//                resp_rdata/err     - response payload
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = DMEM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int               c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [BE_W-1:0]    r_be;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;

    logic               w_err;
    logic               w_last_wait;
    logic               w_wr_en;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_err       = addr_is_bad(r_addr, DEPTH_WORDS);
    assign w_last_wait = (r_state == WAIT) && (r_cnt == '0);
    // The array is written only on the WAIT->RESP edge, never for errors.
    assign w_wr_en     = w_last_wait && r_we && !w_err;

    // r_run is clear while reset is held and sets on the first edge after
    // release, so acceptance is only offered once the clock has taken over.
    assign req_ready  = r_run && (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_err   <= w_err;
                        r_rdata <= (w_err || r_we) ? '0 : w_rd_data;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_be   (r_be),
        .idx     (r_addr[c_IDX_W+1:2]),
        .wr_data (r_wdata),
        .rd_data (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Expected responses
//                come from a word-array model and are queued at request
//                acceptance, then popped when the response appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 4096;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [31:0] req_addr   = '0;
    logic [31:0] req_wdata  = '0;
    logic [3:0]  req_be     = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    dmem_responder #(
        .LATENCY     (LAT),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sbq[$];
    logic [31:0] model [DEPTH];

    // Store waiting to be applied to the model when its response arrives.
    bit          p_valid = 1'b0;
    int          p_idx   = 0;
    logic [31:0] p_wdata = '0;
    logic [3:0]  p_be    = '0;

    bit          chk_tput = 1'b0;
    time         last_acc = 0;

    task automatic start_req(input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output bit ok);
        exp_t e;
        int   n;
        bit   bad_a;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (req_ready === 1'b1);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        bad_a   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
        e.err   = bad_a;
        e.rdata = (!we && !bad_a) ? model[addr[13:2]] : 32'h0;
        p_valid = we && !bad_a;
        p_idx   = int'(addr[13:2]);
        p_wdata = wdata;
        p_be    = be;
        @(posedge clk);
        if (chk_tput && last_acc != 0) begin
            total++;
            if (($time - last_acc) !== time'((LAT + 2) * 10)) begin
                bad++;
                $display("FAIL throughput: period=%0t required %0d", $time - last_acc, (LAT + 2) * 10);
            end
        end
        last_acc = $time;
        sbq.push_back(e);
        #1;
        // Junk on the request bus while busy must be ignored.
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic finish_resp(input int stall, output logic [31:0] rd);
        int          edges;
        exp_t        e;
        logic [31:0] held_d;
        logic        held_e;
        rd         = 'x;
        resp_ready = (stall == 0);
        edges      = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (resp_valid !== 1'b1 && edges < 40);
        total++;
        if (resp_valid !== 1'b1 || edges != LAT) begin
            bad++;
            $display("FAIL resp_latency: edges=%0d valid=%b required %0d edges", edges, resp_valid, LAT);
        end
        if (resp_valid !== 1'b1) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            p_valid   = 1'b0;
            req_valid = 1'b0;
            return;
        end
        held_d = resp_rdata;
        held_e = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== held_d || resp_err !== held_e || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: cycle=%0d valid=%b rdata=%h err=%b req_ready=%b required 1/%h/%b/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, held_d, held_e);
            end
        end
        resp_ready = 1'b1;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got rdata=%h err=%b required a queued entry", resp_rdata, resp_err);
        end else begin
            e = sbq.pop_front();
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                bad++;
                $display("FAIL resp_data: rdata=%h err=%b required rdata=%h err=%b",
                         resp_rdata, resp_err, e.rdata, e.err);
            end
        end
        if (p_valid) begin
            for (int b = 0; b < 4; b++)
                if (p_be[b]) model[p_idx][8*b +: 8] = p_wdata[8*b +: 8];
            p_valid = 1'b0;
        end
        rd = resp_rdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL back_to_idle: resp_valid=%b req_ready=%b required 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall, output logic [31:0] rd);
        bit ok;
        start_req(we, addr, wdata, be, ok);
        rd = 'x;
        if (ok) finish_resp(stall, rd);
    endtask

    task automatic do_reset_release();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b err=%b rdata=%h req_ready=%b required 0/0/0/0",
                     resp_valid, resp_err, resp_rdata, req_ready);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: req_ready=%b required 0", req_ready);
        end
        @(posedge clk); #1;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_release: req_ready=%b resp_valid=%b required 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        txn(1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 0, rd);
        txn(1'b1, 32'h0000_0100, 32'h0000_0005, 4'hF, 0, rd);
        txn(1'b0, 32'h0000_0100, 32'h0,         4'h0, 0, rd);
        total++;
        if (rd !== 32'h0000_0005) begin
            bad++;
            $display("FAIL load_after_store: rdata=%h required 00000005", rd);
        end
        // Last legal word.
        txn(1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, 0, rd);
        txn(1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 0, rd);
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd;
        txn(1'b1, 32'h0000_0104, 32'h0000_0005, 4'hF,    0, rd);
        txn(1'b1, 32'h0000_0104, 32'hAABB_CCDD, 4'b0010, 0, rd);
        txn(1'b0, 32'h0000_0104, 32'h0,         4'h0,    0, rd);
        total++;
        if (rd !== 32'h0000_CC05) begin
            bad++;
            $display("FAIL byte_lane: rdata=%h required 0000CC05", rd);
        end
        txn(1'b1, 32'h0000_0104, 32'h1234_5678, 4'b0000, 0, rd);
        txn(1'b0, 32'h0000_0104, 32'h0,         4'h0,    0, rd);
        txn(1'b1, 32'h0000_0108, 32'h0102_0304, 4'hF,    0, rd);
        txn(1'b1, 32'h0000_0108, 32'hF0E0_D0C0, 4'b1001, 0, rd);
        txn(1'b0, 32'h0000_0108, 32'h0,         4'h0,    0, rd);
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        txn(1'b0, 32'h0000_0102, 32'h0,         4'h0, 0, rd);
        txn(1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF, 0, rd);
        txn(1'b1, 32'h0000_0101, 32'hDEAD_BEEF, 4'hF, 0, rd);
        txn(1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, rd);
        txn(1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, rd);
        total++;
        if (rd !== 32'h1122_3344) begin
            bad++;
            $display("FAIL word0_untouched: rdata=%h required 11223344", rd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3, rd);
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        bit          ok;
        txn(1'b1, 32'h0000_0200, 32'h0, 4'hF, 0, rd);
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, rd);
        start_req(1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, ok);
        reset_n   = 1'b0;
        req_valid = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_wait: valid=%b err=%b rdata=%h req_ready=%b required 0/0/0/0",
                     resp_valid, resp_err, resp_rdata, req_ready);
        end
        if (ok && sbq.size() > 0) void'(sbq.pop_front());
        p_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        do_reset_release();
        txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL aborted_store: rdata=%h required 00000000", rd);
        end
    endtask

    task automatic test_reset_mid_resp();
        logic [31:0] rd;
        bit          ok;
        int          n;
        start_req(1'b0, 32'h0000_0104, 32'h0, 4'h0, ok);
        resp_ready = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        reset_n   = 1'b0;
        req_valid = 1'b0;
        #1;
        total++;
        if (n != LAT || resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_resp: edges=%0d valid=%b rdata=%h required %0d/0/0",
                     n, resp_valid, resp_rdata, LAT);
        end
        if (ok && sbq.size() > 0) void'(sbq.pop_front());
        @(posedge clk);
        do_reset_release();
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, rd);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] src [128];
        for (int i = 0; i < 128; i++) begin
            src[i] = $urandom;
            txn(1'b1, 32'h100 + 32'(i * 4), src[i], 4'hF, 0, rd);
        end
        chk_tput = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 128; i++) begin
            txn(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0, 0, rd);
            txn(1'b1, 32'h300 + 32'(i * 4), rd,    4'hF, 0, rd);
        end
        chk_tput = 1'b0;
        for (int i = 0; i < 128; i++) begin
            txn(1'b0, 32'h300 + 32'(i * 4), 32'h0, 4'h0, 0, rd);
            total++;
            if (rd !== src[i]) begin
                bad++;
                $display("FAIL copy_dest: word=%0d rdata=%h required %h", i, rd, src[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_stall();
        test_reset_mid_wait();
        test_reset_mid_resp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving the number of wait cycles between request acceptance and response (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 4096, giving the number of 32-bit words in the backing array.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 The block SHALL have port req_be, input, 4 bits: byte enables for a store; bit n selects byte lane n, and the field is ignored for loads.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: load data; it is 0 for stores and for errors.
REQ-014 The block SHALL have port resp_err, output, 1 bit: the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; on that edge the block latches we/addr/wdata/be, moves to WAIT, and loads the counter with LATENCY-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle; on the edge where the counter equals 0, the block moves to RESP.
REQ-019 Consequently, resp_valid SHALL rise exactly LATENCY edges after the acceptance edge.
REQ-020 On the WAIT->RESP edge, a valid store SHALL write only the byte lanes whose be bit is 1 at word index addr[13:2]; this is the only point at which the array is written.
REQ-021 On the WAIT->RESP edge, a valid load SHALL register the addressed word into resp_rdata.
REQ-022 A request SHALL be an error if addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS; an error sets resp_err=1, forces resp_rdata=0, and performs no array write.
REQ-023 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL stay stable until a rising edge with resp_ready=1, after which the block moves to IDLE.
REQ-024 resp_ready held low SHALL stall the block indefinitely in RESP; while stalled, req_ready stays 0 and no new request is accepted.
REQ-025 Back-to-back operation: the earliest next acceptance SHALL be the edge after RESP->IDLE, giving LATENCY+2 cycles per transaction under zero stall.
REQ-026 A store with be=0000 SHALL be legal: it produces a normal response with no array change.
REQ-027 A load following a store to the same address SHALL return the new value, because the write commits before the RESP of that store.
REQ-028 req_* inputs sampled outside the acceptance edge SHALL be ignored.

Reset
REQ-029 Asserting reset_n=0 SHALL immediately force state=IDLE, counter=0, resp_valid=0, resp_err=0 and resp_rdata=0.
REQ-030 Deasserting reset_n SHALL take effect synchronously with clk, so that req_ready=1 from the first edge after release.
REQ-031 Reset mid-WAIT SHALL abort the pending request, and a pending store SHALL NOT be committed.
REQ-032 Reset mid-RESP SHALL drop the response.
REQ-033 Array contents SHALL NOT be cleared by reset; the bench initialises them.

Structure
REQ-034 Package dmem_pkg SHALL hold the state type (IDLE/WAIT/RESP), DMEM_WORDS_DEFAULT=4096, and the width constants ADDR_W=32, DATA_W=32 and BE_W=4.
REQ-035 The block SHALL instantiate one sub-module, dmem_array: a word-wide array with per-byte write enable and synchronous write, whose read timing is chosen to satisfy REQ-021.
REQ-036 The FSM, counter, error check and response registers SHALL reside in dmem_responder.

Verification
REQ-037 Scenario: store 0x00000005 to 0x100 (be=1111), then load 0x100 -> the load returns 0x00000005 with resp_err=0, and resp_valid rises exactly 2 edges after each acceptance.
REQ-038 Scenario: with word 0x104 = 0x00000005, store 0xAABBCCDD with be=0010 to 0x104, then load 0x104 -> the load returns 0x0000CC05.
REQ-039 Scenario: load 0x102, then store to 0x4000 (DEPTH_WORDS=4096) -> both give resp_err=1 and resp_rdata=0, and word 0 is unchanged.
REQ-040 Scenario: load 0x100 with resp_ready held 0 for 3 cycles after resp_valid -> resp_valid and resp_rdata are stable for 4 cycles, req_ready=0 throughout, and IDLE follows the handshake edge.
REQ-041 Scenario: assert reset_n=0 during the WAIT of a store of 0x12345678 to 0x200, with 0x200 initialised to 0 -> state returns to IDLE with outputs 0, and a subsequent load of 0x200 returns 0x00000000.
REQ-042 Scenario: copy loop of 128 words from 0x100.. to 0x300.., loading and storing with resp_ready=1 -> all destination words match the source, and each transaction takes LATENCY+2 cycles.
